// File: rtl/sc_frogger_round_controller.sv
// Round/lives sequencer for Frogger: sequences clear, respawn and freeze, owns lives and the round-transition timer.
// Optional level counter with a shorter win pause is enabled by defining SC_ROUNDCTRL_LEVEL_EN.
module sc_frogger_round_controller #(
    parameter int LIVES_INIT        = 3,
    parameter int LIVES_WIDTH       = 2,
    parameter int TRANSITION_CYCLES = 50_000_000,
    parameter int TIMER_WIDTH       = 26
) (
    input  logic                   SC_STATEMACHINEGAME_CLOCK_50,
    input  logic                   SC_STATEMACHINEGAME_RESET_InHigh,
    input  logic                   SC_ROUNDCTRL_startButton_InLow,
    input  logic                   SC_ROUNDCTRL_collision_InLow,
    input  logic                   SC_ROUNDCTRL_goal_InLow,
    output logic                   SC_ROUNDCTRL_clear_OutLow,
    output logic                   SC_ROUNDCTRL_respawn_OutLow,
    output logic                   SC_ROUNDCTRL_freeze_OutHigh,
    output logic [LIVES_WIDTH-1:0] SC_ROUNDCTRL_lives_Out,
    output logic                   SC_ROUNDCTRL_gameover_OutHigh,
    output logic                   SC_ROUNDCTRL_win_OutHigh
`ifdef SC_ROUNDCTRL_LEVEL_EN
    ,
    output logic [3:0]             SC_ROUNDCTRL_level_Out
`endif
);

    // state     | meaning
    // IDLE      | after reset, waiting for start
    // INIT      | clear matrix, reload lives
    // PLAY      | frog moving, watching collision/goal
    // HIT       | lose a life
    // HIT_WAIT  | pause before respawn
    // RESPAWN   | reload frog at start row
    // WIN_WAIT  | pause after reaching goal row
    // GAMEOVER  | no lives left, waiting for a fresh start press
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_PLAY     = 3'd2,
        S_HIT      = 3'd3,
        S_HIT_WAIT = 3'd4,
        S_RESPAWN  = 3'd5,
        S_WIN_WAIT = 3'd6,
        S_GAMEOVER = 3'd7
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] HIT_LAST  = TIMER_WIDTH'(TRANSITION_CYCLES - 1);
`ifdef SC_ROUNDCTRL_LEVEL_EN
    localparam logic [TIMER_WIDTH-1:0] WIN_LAST  = TIMER_WIDTH'(TRANSITION_CYCLES / 2 - 1);
`else
    localparam logic [TIMER_WIDTH-1:0] WIN_LAST  = HIT_LAST;
`endif
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;
    localparam logic [LIVES_WIDTH-1:0] LIVES_RST = LIVES_WIDTH'(LIVES_INIT);

    state_t                   state_q, state_d;
    logic [LIVES_WIDTH-1:0]   lives_q, lives_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic                     start_prev_q, start_prev_d;
    logic [TIMER_WIDTH-1:0]   timer_inc;
`ifdef SC_ROUNDCTRL_LEVEL_EN
    logic [3:0]               level_q, level_d;
`endif

    always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
        if (SC_STATEMACHINEGAME_RESET_InHigh) begin
            state_q      <= S_IDLE;
            lives_q      <= LIVES_RST;
            timer_q      <= '0;
            start_prev_q <= 1'b1;
`ifdef SC_ROUNDCTRL_LEVEL_EN
            level_q      <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            start_prev_q <= start_prev_d;
`ifdef SC_ROUNDCTRL_LEVEL_EN
            level_q      <= level_d;
`endif
        end
    end

    // Saturating increment keeps the timer from wrapping if a wait is ever held past its terminal count.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        timer_d      = timer_q;
        start_prev_d = SC_ROUNDCTRL_startButton_InLow;
`ifdef SC_ROUNDCTRL_LEVEL_EN
        level_d      = level_q;
`endif
        SC_ROUNDCTRL_clear_OutLow     = 1'b1;
        SC_ROUNDCTRL_respawn_OutLow   = 1'b1;
        SC_ROUNDCTRL_freeze_OutHigh   = 1'b1;
        SC_ROUNDCTRL_gameover_OutHigh = 1'b0;
        SC_ROUNDCTRL_win_OutHigh      = 1'b0;
        SC_ROUNDCTRL_lives_Out        = lives_q;

        case (state_q)
            S_IDLE: begin
                if (!SC_ROUNDCTRL_startButton_InLow) begin
                    state_d = S_INIT;
`ifdef SC_ROUNDCTRL_LEVEL_EN
                    level_d = 4'd0;
`endif
                end
            end
            S_INIT: begin
                SC_ROUNDCTRL_clear_OutLow = 1'b0;
                lives_d = LIVES_RST;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                SC_ROUNDCTRL_freeze_OutHigh = 1'b0;
                if (!SC_ROUNDCTRL_collision_InLow) begin
                    state_d = S_HIT;
                end else if (!SC_ROUNDCTRL_goal_InLow) begin
                    state_d = S_WIN_WAIT;
                    timer_d = '0;
                end
            end
            S_HIT: begin
                timer_d = '0;
                if (lives_q != '0) begin
                    lives_d = lives_q - LIVES_WIDTH'(1);
                end
                state_d = (lives_q == LIVES_WIDTH'(1)) ? S_GAMEOVER : S_HIT_WAIT;
            end
            S_HIT_WAIT: begin
                timer_d = timer_inc;
                if (timer_q == HIT_LAST) begin
                    state_d = S_RESPAWN;
                end
            end
            S_RESPAWN: begin
                SC_ROUNDCTRL_respawn_OutLow = 1'b0;
                SC_ROUNDCTRL_freeze_OutHigh = 1'b0;
                state_d = S_PLAY;
            end
            S_WIN_WAIT: begin
                SC_ROUNDCTRL_win_OutHigh = 1'b1;
                timer_d = timer_inc;
                if (timer_q == WIN_LAST) begin
                    state_d = S_INIT;
`ifdef SC_ROUNDCTRL_LEVEL_EN
                    if (level_q != 4'd15) begin
                        level_d = level_q + 4'd1;
                    end
`endif
                end
            end
            S_GAMEOVER: begin
                SC_ROUNDCTRL_gameover_OutHigh = 1'b1;
                SC_ROUNDCTRL_lives_Out        = '0;
                // Only a fresh press restarts; a button still held from play must be released first.
                if (!SC_ROUNDCTRL_startButton_InLow && start_prev_q) begin
                    state_d = S_INIT;
`ifdef SC_ROUNDCTRL_LEVEL_EN
                    level_d = 4'd0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef SC_ROUNDCTRL_LEVEL_EN
    assign SC_ROUNDCTRL_level_Out = level_q;
`endif

endmodule
